sequenciador_de_instrucoes: RTL and testbench

Multi-cycle instruction sequencer for the 9-bit processor datapath (register file R0..R7, accumulator A, ALU result register G, shared bus mux). It accepts an instruction word on a run handshake and latches it into an internal instruction register (IR). It then steps a T1..T3 state machine that drives the bus mux select, register write enables, A/G enables and ALU operation, and pulses done on completion. It replaces the free-running external step counter.

---
 rtl/sequenciador_de_instrucoes.sv | 160 ++++++++++++++++
 tb/tb_sequenciador_de_instrucoes.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_de_instrucoes.sv
// ============================================================================
// Module      : sequenciador_de_instrucoes
// Description : Multi-cycle T1..T3 instruction sequencer for the 9-bit datapath.
//               Optional retired-instruction counter: SEQ_INSTR_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequenciador_de_instrucoes #(
    parameter logic [3:0] SEL_DIN = 4'd8,
    parameter logic [3:0] SEL_G   = 4'd9
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [8:0]  iin,
    output logic [3:0]  mux_select,
    output logic [7:0]  regs_enable,
    output logic        a_enable,
    output logic        alu_output_enable,
    output logic [1:0]  alu_op_select,
    output logic        out_enable,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_REP = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic [8:0] ir_q;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_onehot;

    assign opcode    = ir_q[8:6];
    assign rx        = ir_q[5:3];
    assign ry        = ir_q[2:0];
    assign rx_onehot = 8'b0000_0001 << rx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ir_q    <= 9'h000;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && run) begin
                ir_q <= iin;
            end
        end
    end

    // Outputs depend only on state and IR so iin may change freely mid-instruction.
    always_comb begin
        state_d           = state_q;
        mux_select        = 4'd0;
        regs_enable       = 8'h00;
        a_enable          = 1'b0;
        alu_output_enable = 1'b0;
        alu_op_select     = 2'b00;
        out_enable        = 1'b0;
        done              = 1'b0;
        illegal           = 1'b0;
        busy              = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_REP: begin
                        mux_select  = {1'b0, ry};
                        regs_enable = rx_onehot;
                        done        = 1'b1;
                        state_d     = IDLE;
                    end
                    OP_LDI: begin
                        mux_select  = SEL_DIN;
                        regs_enable = rx_onehot;
                        done        = 1'b1;
                        state_d     = IDLE;
                    end
                    OP_OUT: begin
                        mux_select = {1'b0, rx};
                        out_enable = 1'b1;
                        done       = 1'b1;
                        state_d    = IDLE;
                    end
                    OP_ADD, OP_SUB, OP_NAN: begin
                        mux_select = {1'b0, rx};
                        a_enable   = 1'b1;
                        state_d    = T2;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            T2: begin
                mux_select        = {1'b0, ry};
                alu_output_enable = 1'b1;
                case (opcode)
                    OP_SUB:  alu_op_select = 2'b01;
                    OP_NAN:  alu_op_select = 2'b10;
                    default: alu_op_select = 2'b00;
                endcase
                state_d = T3;
            end
            T3: begin
                mux_select  = SEL_G;
                regs_enable = rx_onehot;
                done        = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= 16'h0000;
        end else if (done && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_de_instrucoes.sv
// ============================================================================
// Module      : tb_sequenciador_de_instrucoes
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequenciador_de_instrucoes;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [8:0]  iin;
    logic [3:0]  mux_select;
    logic [7:0]  regs_enable;
    logic        a_enable;
    logic        alu_output_enable;
    logic [1:0]  alu_op_select;
    logic        out_enable;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;

    sequenciador_de_instrucoes dut (
        .clock             (clock),
        .resetn            (resetn),
        .run               (run),
        .iin               (iin),
        .mux_select        (mux_select),
        .regs_enable       (regs_enable),
        .a_enable          (a_enable),
        .alu_output_enable (alu_output_enable),
        .alu_op_select     (alu_op_select),
        .out_enable        (out_enable),
        .busy              (busy),
        .done              (done),
        .illegal           (illegal),
        .instr_count       (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] mux;
        logic [7:0] regs;
        logic       a_en;
        logic       g_en;
        logic [1:0] op;
        logic       out_en;
        logic       busy;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [8:0]     iin;
        int             n;
        outs_t [2:0]    exp;
    } vec_t;

    localparam outs_t ZERO = '0;

    function automatic outs_t mk(input logic [3:0] m, input logic [7:0] r, input logic a,
                                 input logic g, input logic [1:0] op, input logic o,
                                 input logic d, input logic il);
        return {m, r, a, g, op, o, 1'b1, d, il};
    endfunction

    // Reference: list of per-cycle outputs an instruction produces after acceptance.
    function automatic void model_steps(input logic [8:0] ins, output int n, output outs_t [2:0] e);
        int         op;
        int         x;
        int         y;
        logic [7:0] oh;
        op = int'(ins[8:6]);
        x  = int'(ins[5:3]);
        y  = int'(ins[2:0]);
        oh = 8'(1 << x);
        e  = '0;
        if (op == 7) begin
            n = 1; e[0] = mk(4'(y), oh, 0, 0, 2'd0, 0, 1, 0);
        end else if (op == 5) begin
            n = 1; e[0] = mk(4'd8, oh, 0, 0, 2'd0, 0, 1, 0);
        end else if (op == 4) begin
            n = 1; e[0] = mk(4'(x), 8'h00, 0, 0, 2'd0, 1, 1, 0);
        end else if (op <= 2) begin
            n = 3;
            e[0] = mk(4'(x), 8'h00, 1, 0, 2'd0, 0, 0, 0);
            e[1] = mk(4'(y), 8'h00, 0, 1, 2'(op), 0, 0, 0);
            e[2] = mk(4'd9, oh, 0, 0, 2'd0, 0, 1, 0);
        end else begin
            n = 1; e[0] = mk(4'd0, 8'h00, 0, 0, 2'd0, 0, 1, 1);
        end
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = {mux_select, regs_enable, a_enable, alu_output_enable, alu_op_select,
               out_enable, busy, done, illegal};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mux,regs,a,g,op,out,busy,done,ill)",
                     name, act, exp);
        end
    endtask

    task automatic check_count(input string name);
        logic [15:0] exp;
`ifdef SEQ_INSTR_COUNT_EN
        exp = 16'(cnt_model);
`else
        exp = 16'h0000;
`endif
        checks++;
        if (instr_count !== exp) begin
            errors++;
            $display("FAIL %s: instr_count got %0d expected %0d", name, instr_count, exp);
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns in the same position.
    task automatic run_instr(input string name, input logic [8:0] ins, input int n,
                             input outs_t [2:0] e, input logic keep_run);
        check_outs({name, "_idle"}, ZERO);
        run = 1'b1;
        iin = ins;
        for (int s = 0; s < n; s++) begin
            @(posedge clock); #1;
            run = 1'($urandom_range(0, 1));
            iin = 9'($urandom);
            check_outs($sformatf("%s_T%0d", name, s + 1), e[s]);
        end
        @(posedge clock); #1;
        run = keep_run;
        if (cnt_model < 65535) cnt_model++;
        check_count({name, "_cnt"});
    endtask

    vec_t       vecs [8];
    outs_t [2:0] me;
    int         mn;
    logic [8:0] ri;

    initial begin
        vecs[0] = '{9'b111_010_101, 1, '0};
        vecs[0].exp[0] = mk(4'd5, 8'h04, 0, 0, 2'd0, 0, 1, 0);
        vecs[1] = '{9'b101_111_000, 1, '0};
        vecs[1].exp[0] = mk(4'd8, 8'h80, 0, 0, 2'd0, 0, 1, 0);
        vecs[2] = '{9'b001_001_100, 3, '0};
        vecs[2].exp[0] = mk(4'd1, 8'h00, 1, 0, 2'd0, 0, 0, 0);
        vecs[2].exp[1] = mk(4'd4, 8'h00, 0, 1, 2'd1, 0, 0, 0);
        vecs[2].exp[2] = mk(4'd9, 8'h02, 0, 0, 2'd0, 0, 1, 0);
        vecs[3] = '{9'b100_110_000, 1, '0};
        vecs[3].exp[0] = mk(4'd6, 8'h00, 0, 0, 2'd0, 1, 1, 0);
        vecs[4] = '{9'b011_000_000, 1, '0};
        vecs[4].exp[0] = mk(4'd0, 8'h00, 0, 0, 2'd0, 0, 1, 1);
        vecs[5] = '{9'b110_111_111, 1, '0};
        vecs[5].exp[0] = mk(4'd0, 8'h00, 0, 0, 2'd0, 0, 1, 1);
        vecs[6] = '{9'b000_011_011, 3, '0};
        vecs[6].exp[0] = mk(4'd3, 8'h00, 1, 0, 2'd0, 0, 0, 0);
        vecs[6].exp[1] = mk(4'd3, 8'h00, 0, 1, 2'd0, 0, 0, 0);
        vecs[6].exp[2] = mk(4'd9, 8'h08, 0, 0, 2'd0, 0, 1, 0);
        vecs[7] = '{9'b010_000_111, 3, '0};
        vecs[7].exp[0] = mk(4'd0, 8'h00, 1, 0, 2'd0, 0, 0, 0);
        vecs[7].exp[1] = mk(4'd7, 8'h00, 0, 1, 2'd2, 0, 0, 0);
        vecs[7].exp[2] = mk(4'd9, 8'h01, 0, 0, 2'd0, 0, 1, 0);

        resetn = 1'b0;
        run    = 1'b0;
        iin    = 9'h000;
        #1;
        check_outs("reset_outs", ZERO);
        check_count("reset_cnt");
        @(posedge clock); #1;
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].iin, vecs[i].n, vecs[i].exp, 1'b0);
        end

        // Reset asserted during T2 of an ADD: outputs clear at once, no done.
        run = 1'b1;
        iin = 9'b000_011_011;
        @(posedge clock); #1;
        run = 1'b0;
        check_outs("rst_T1", vecs[6].exp[0]);
        @(posedge clock); #1;
        check_outs("rst_T2", vecs[6].exp[1]);
        #2 resetn = 1'b0;
        #1;
        cnt_model = 0;
        check_outs("rst_async", ZERO);
        check_count("rst_cnt");
        @(posedge clock); #1;
        check_outs("rst_held", ZERO);
        resetn = 1'b1;
        @(posedge clock); #1;
        run_instr("post_rst", vecs[0].iin, vecs[0].n, vecs[0].exp, 1'b0);

        // Run held high across five REP instructions.
        for (int i = 0; i < 5; i++) begin
            run_instr($sformatf("held%0d", i), vecs[0].iin, vecs[0].n, vecs[0].exp,
                      (i < 4) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < 60; i++) begin
            ri = 9'($urandom);
            model_steps(ri, mn, me);
            run_instr($sformatf("rnd%0d_%h", i, ri), ri, mn, me, 1'b0);
        end

        check_outs("final_idle", ZERO);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
